pll_mdrp_ctrl: RTL and testbench
================================

Name: pll_mdrp_ctrl

Overview:
- Initiator for the PLLA dynamic-reconfiguration (MDRP) port. It drives the opcode, address-increment and write-data inputs of the PLL wrapper, and samples the wrapper's read-data output.
- Converts host commands into MDRP sequences. A command is a burst read or write of 1–16 bytes.
- An optional PLL reset/relock step after a command lets frequency changes take effect.
- Sits between the board control logic (runtime clock-retune requests) and the DDR3/video PLL wrappers. Clocked by the same clock that feeds the PLL's MDCLK.

Parameters:
- RD_LATENCY, 1, cycles from a READ opcode to valid read data on mdrdo (1..3).
- RESET_CYCLES, 16, width of the pll_reset pulse in clk cycles (>=2).
- LOCK_TIMEOUT, 65535, max clk cycles to wait for lock after a PLL reset (16-bit counter).

Ports:
- clk  in  1  system clock, also routed to the PLL MDCLK
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  controller idle, command accepted on valid&ready
- cmd_write  in  1  1=write burst, 0=read burst
- cmd_addr  in  8  MDRP start register address
- cmd_len  in  4  beats minus one (0..15 → 1..16 accesses)
- cmd_relock  in  1  after the burst, pulse pll_reset and wait for lock
- wr_valid  in  1  write byte available
- wr_ready  out  1  write byte consumed on valid&ready
- wr_data  in  8  write byte
- rd_valid  out  1  one-cycle strobe, rd_data valid (no backpressure)
- rd_data  out  8  read byte
- done  out  1  one-cycle pulse, command complete
- err_timeout  out  1  lock timeout flag; sticky until next command accept
- busy  out  1  high from accept through done
- mdopc  out  2  MDRP opcode: 00 NOP, 01 WRITE, 10 READ, 11 ADDR-LOAD
- mdainc  out  1  post-access address increment
- mdwdi  out  8  MDRP write data / address
- mdrdo  in  8  MDRP read data
- pll_reset  out  1  PLL reset, active high
- pll_lock  in  1  PLL lock (asynchronous; internally synchronized with 2 flops)

Behaviour:
- All outputs registered.
- Reset values: all outputs 0. mdopc=00, pll_reset=0, err_timeout=0, cmd_ready=0.
- cmd_ready rises the first clk after rst_n deasserts.
- Async reset mid-operation aborts immediately, with mdopc=00 and pll_reset=0 on assertion.

State machine:
- IDLE: cmd_ready=1.
  - On cmd_valid & cmd_ready: latch cmd fields, beat counter=cmd_len, clear err_timeout, cmd_ready=0, busy=1 → ADDR.
- ADDR: one cycle, mdopc=11, mdwdi=cmd_addr → WRITE_WAIT if write, else READ_ISSUE.
- WRITE_WAIT: wr_ready=1.
  - On wr_valid & wr_ready: next cycle is one WRITE issue cycle (mdopc=01, mdwdi=wr_data, mdainc=1 unless last beat), wr_ready=0 during the issue.
  - After the issue: decrement the counter. If it was 0 → POST, else → WRITE_WAIT.
  - Max rate: one byte per 2 cycles.
- READ_ISSUE: one cycle, mdopc=10, mdainc=1 unless last beat → READ_WAIT.
- READ_WAIT: RD_LATENCY cycles. mdrdo is sampled at the end of the last one.
  - rd_valid=1 with rd_data in the following cycle, which is also the next READ_ISSUE, or POST if counter was 0.
  - Issue-to-rd_valid distance = RD_LATENCY+1 cycles.
- POST: cmd_relock=0 → DONE; else → PLL_RST.
- PLL_RST: pll_reset=1 for exactly RESET_CYCLES cycles → LOCK_WAIT.
- LOCK_WAIT: counter from 0.
  - Synchronized lock high → DONE.
  - Counter reaches LOCK_TIMEOUT → err_timeout=1, DONE.
- DONE: done=1 for one cycle, busy=0 next cycle, cmd_ready=1 next cycle → IDLE.

Rules and boundary conditions:
- mdopc=00 and mdainc=0 in every non-issue cycle.
- mdwdi holds its last value when mdopc=00.
- Address wrap 0xFF→0x00 is handled by the PLL auto-increment; the controller issues no extra ADDR cycle.
- cmd_len=0: single access, mdainc=0.
- cmd_valid while busy: ignored.
- wr_valid outside WRITE_WAIT: ignored, not consumed.
- pll_lock already high when LOCK_WAIT is entered: valid only after the synchronizer. Lock is sampled only in LOCK_WAIT, so stale pre-reset lock is masked by the RESET_CYCLES>=2 pulse.
- A lock glitch during PLL_RST has no effect.

Test Plan:
- Write, addr 0x10, len 0, wr_data 0xA5 presented immediately → mdopc 11/0x10, 1 idle cycle, 01/0xA5 with mdainc=0, done 2 cycles later, no pll_reset.
- Read burst, addr 0x20, len 3, RD_LATENCY=1, model returns 0x20+offset → four mdopc=10 issues spaced 2 cycles apart, mdainc=1,1,1,0, rd_data 0x20,0x21,0x22,0x23, then done.
- Write, len 2, wr_valid stalled 5 cycles between bytes → wr_ready held high, no mdopc activity during the stall, exactly 3 WRITE issues.
- Relock, lock returns 40 cycles after pll_reset falls → pll_reset high exactly 16 cycles, done after lock + synchronizer delay, err_timeout=0.
- Relock with LOCK_TIMEOUT=100, lock held low → done at timeout, err_timeout=1 and held, cleared on next command accept.
- rst_n asserted mid read burst → mdopc=00, pll_reset=0, rd_valid=0 immediately; after release cmd_ready=1, next command executes normally.

Source files
------------

// File: rtl/pll_mdrp_ctrl_if.sv
// Host command/data bus for the PLL MDRP controller.
// master = board control logic, slave = pll_mdrp_ctrl.
interface pll_mdrp_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [3:0] cmd_len;
  logic       cmd_relock;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       done;
  logic       err_timeout;
  logic       busy;

  modport master (
    output cmd_valid, cmd_write, cmd_addr,
    output cmd_len, cmd_relock,
    output wr_valid, wr_data,
    input  cmd_ready, wr_ready,
    input  rd_valid, rd_data,
    input  done, err_timeout, busy
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr,
    input  cmd_len, cmd_relock,
    input  wr_valid, wr_data,
    output cmd_ready, wr_ready,
    output rd_valid, rd_data,
    output done, err_timeout, busy
  );
endinterface

// File: rtl/pll_mdrp_ctrl.sv
// PLL MDRP initiator: host burst read/write -> MDRP opcodes,
// optional PLL reset/relock. Ports: clk, rst_n, host (slave
// modport: cmd/wr/rd/done/err_timeout/busy), mdopc/mdainc/mdwdi
// to the PLL, mdrdo from it, pll_reset out, pll_lock in (async).
module pll_mdrp_ctrl #(
  parameter int RD_LATENCY   = 1,
  parameter int RESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pll_mdrp_ctrl_if.slave        host,
  output logic [1:0]            mdopc,
  output logic                  mdainc,
  output logic [7:0]            mdwdi,
  input  logic [7:0]            mdrdo,
  output logic                  pll_reset,
  input  logic                  pll_lock
);

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_AL  = 2'b11;

  localparam logic [15:0] RD_LAST  = 16'(RD_LATENCY - 1);
  localparam logic [15:0] RST_LAST = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] LOCK_MAX = 16'(LOCK_TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_WR_WAIT,
    S_WR_ISSUE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_POST,
    S_PLL_RST,
    S_LOCK_WAIT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] tmr_q, tmr_d;
  logic        write_q, write_d;
  logic        relock_q, relock_d;
  logic [1:0]  sync_q;
  logic        lock_s;

  logic        cmd_ready_q, cmd_ready_d;
  logic        wr_ready_q, wr_ready_d;
  logic        rd_valid_q, rd_valid_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic [1:0]  mdopc_q, mdopc_d;
  logic        mdainc_q, mdainc_d;
  logic [7:0]  mdwdi_q, mdwdi_d;
  logic        pll_reset_q, pll_reset_d;

  assign lock_s = sync_q[1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    write_d   = write_q;
    relock_d  = relock_q;
    err_d     = err_q;
    rd_data_d = rd_data_q;
    mdwdi_d   = mdwdi_q;
    mdopc_d   = OP_NOP;
    rd_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (host.cmd_valid && cmd_ready_q) begin
          write_d  = host.cmd_write;
          relock_d = host.cmd_relock;
          cnt_d    = host.cmd_len;
          err_d    = 1'b0;
          mdwdi_d  = host.cmd_addr;
          mdopc_d  = OP_AL;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (write_q) begin
          state_d = S_WR_WAIT;
        end else begin
          mdopc_d = OP_RD;
          state_d = S_RD_ISSUE;
        end
      end
      S_WR_WAIT: begin
        if (host.wr_valid && wr_ready_q) begin
          mdopc_d = OP_WR;
          mdwdi_d = host.wr_data;
          state_d = S_WR_ISSUE;
        end
      end
      S_WR_ISSUE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_POST;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = S_WR_WAIT;
        end
      end
      S_RD_ISSUE: begin
        tmr_d   = 16'd0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (tmr_q == RD_LAST) begin
          // last wait cycle: mdrdo holds this beat's data
          rd_valid_d = 1'b1;
          rd_data_d  = mdrdo;
          if (cnt_q == 4'd0) begin
            state_d = S_POST;
          end else begin
            cnt_d   = cnt_q - 4'd1;
            mdopc_d = OP_RD;
            state_d = S_RD_ISSUE;
          end
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      S_POST: begin
        if (relock_q) begin
          tmr_d   = 16'd0;
          state_d = S_PLL_RST;
        end else begin
          state_d = S_DONE;
        end
      end
      S_PLL_RST: begin
        if (tmr_q == RST_LAST) begin
          tmr_d   = 16'd0;
          state_d = S_LOCK_WAIT;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      S_LOCK_WAIT: begin
        if (lock_s) begin
          state_d = S_DONE;
        end else if (tmr_q == LOCK_MAX) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // cnt_d already reflects the beat being issued
    mdainc_d    = (mdopc_d == OP_WR || mdopc_d == OP_RD)
                  && (cnt_d != 4'd0);
    cmd_ready_d = (state_d == S_IDLE);
    wr_ready_d  = (state_d == S_WR_WAIT);
    busy_d      = (state_d != S_IDLE);
    pll_reset_d = (state_d == S_PLL_RST);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      tmr_q       <= 16'd0;
      write_q     <= 1'b0;
      relock_q    <= 1'b0;
      sync_q      <= 2'b00;
      cmd_ready_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= 8'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      mdopc_q     <= OP_NOP;
      mdainc_q    <= 1'b0;
      mdwdi_q     <= 8'd0;
      pll_reset_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      write_q     <= write_d;
      relock_q    <= relock_d;
      sync_q      <= {sync_q[0], pll_lock};
      cmd_ready_q <= cmd_ready_d;
      wr_ready_q  <= wr_ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      mdopc_q     <= mdopc_d;
      mdainc_q    <= mdainc_d;
      mdwdi_q     <= mdwdi_d;
      pll_reset_q <= pll_reset_d;
    end
  end

  assign host.cmd_ready   = cmd_ready_q;
  assign host.wr_ready    = wr_ready_q;
  assign host.rd_valid    = rd_valid_q;
  assign host.rd_data     = rd_data_q;
  assign host.done        = done_q;
  assign host.err_timeout = err_q;
  assign host.busy        = busy_q;
  assign mdopc            = mdopc_q;
  assign mdainc           = mdainc_q;
  assign mdwdi            = mdwdi_q;
  assign pll_reset        = pll_reset_q;

endmodule

// File: tb/tb_pll_mdrp_ctrl.sv
// Directed bench for pll_mdrp_ctrl with a small MDRP PLL model.
// Ports: none (top-level testbench).
module tb_pll_mdrp_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mdopc;
  logic       mdainc;
  logic [7:0] mdwdi;
  logic [7:0] mdrdo = 8'h00;
  logic       pll_reset;
  logic       pll_lock;

  int checks = 0;
  int failures = 0;

  pll_mdrp_ctrl_if hif();

  pll_mdrp_ctrl #(
    .RD_LATENCY  (1),
    .RESET_CYCLES(16),
    .LOCK_TIMEOUT(100)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .host     (hif),
    .mdopc    (mdopc),
    .mdainc   (mdainc),
    .mdwdi    (mdwdi),
    .mdrdo    (mdrdo),
    .pll_reset(pll_reset),
    .pll_lock (pll_lock)
  );

  always #5 clk = ~clk;

  // PLL model: address register, memory, read data = address
  logic [7:0] m_addr = 8'h00;
  logic [7:0] mem [256];
  int wr_issues = 0;

  always @(posedge clk) begin
    if (mdopc == 2'b11) begin
      m_addr <= mdwdi;
    end else if (mdopc == 2'b01) begin
      mem[m_addr] <= mdwdi;
      m_addr <= m_addr + {7'd0, mdainc};
      wr_issues <= wr_issues + 1;
    end else if (mdopc == 2'b10) begin
      mdrdo <= m_addr;
      m_addr <= m_addr + {7'd0, mdainc};
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // call at a negedge; returns at the negedge of the ADDR cycle
  task automatic start_cmd(input logic w,
                           input logic [7:0] a,
                           input logic [3:0] l,
                           input logic rl);
    int n;
    hif.cmd_write  = w;
    hif.cmd_addr   = a;
    hif.cmd_len    = l;
    hif.cmd_relock = rl;
    hif.cmd_valid  = 1'b1;
    n = 0;
    while (hif.cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept_bound", 32'(n < 50), 32'd1);
    @(negedge clk);
    hif.cmd_valid = 1'b0;
  endtask

  // read-burst observation, cycle 0 = ADDR cycle
  int nis, nrd, done_at;
  int isc [4];
  int rdc [4];
  logic [7:0] rdv [4];
  logic [3:0] incs;

  task automatic collect_read();
    nis = 0;
    nrd = 0;
    done_at = -1;
    incs = 4'd0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (mdopc == 2'b10) begin
        if (nis < 4) begin
          isc[nis] = k;
          incs[3 - nis] = mdainc;
        end
        nis++;
      end
      if (hif.rd_valid) begin
        if (nrd < 4) begin
          rdv[nrd] = hif.rd_data;
          rdc[nrd] = k;
        end
        nrd++;
      end
      if (hif.done) begin
        done_at = k;
        break;
      end
    end
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (hif.done) begin
        at = k;
        break;
      end
    end
  endtask

  // waits for pll_reset, drops lock, measures the pulse,
  // and glitches lock mid-pulse; ends on first low negedge
  task automatic pll_rst_phase(output int width);
    int n;
    n = 0;
    while (pll_reset !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pll_reset_rise_bound", 32'(n < 20), 32'd1);
    pll_lock = 1'b0;
    width = 0;
    while (pll_reset === 1'b1 && width < 100) begin
      if (width == 5) pll_lock = 1'b1;
      if (width == 8) pll_lock = 1'b0;
      width++;
      @(negedge clk);
    end
  endtask

  int at, wdt, stall_bad, ninc;
  int wr0;

  initial begin
    rst_n = 1'b0;
    hif.cmd_valid = 1'b0;
    hif.cmd_write = 1'b0;
    hif.cmd_addr = 8'h00;
    hif.cmd_len = 4'd0;
    hif.cmd_relock = 1'b0;
    hif.wr_valid = 1'b0;
    hif.wr_data = 8'h00;
    pll_lock = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_outputs",
        {30'd0, mdopc} | {23'd0, mdwdi, mdainc}
        | {25'd0, hif.cmd_ready, hif.busy, hif.done,
           hif.err_timeout, hif.rd_valid, hif.wr_ready,
           pll_reset},
        32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_rst", hif.cmd_ready, 1'b1);

    // single write, len 0
    start_cmd(1'b1, 8'h10, 4'd0, 1'b0);
    chk("w1_addr_op", mdopc, 2'b11);
    chk("w1_addr_val", mdwdi, 8'h10);
    @(negedge clk);
    chk("w1_idle_op", mdopc, 2'b00);
    chk("w1_wr_ready", hif.wr_ready, 1'b1);
    hif.wr_valid = 1'b1;
    hif.wr_data = 8'hA5;
    @(negedge clk);
    hif.wr_valid = 1'b0;
    chk("w1_issue",
        {mdopc, mdwdi, mdainc, hif.wr_ready},
        {2'b01, 8'hA5, 1'b0, 1'b0});
    @(negedge clk);
    chk("w1_post", {hif.done, mdopc, mdwdi},
        {1'b0, 2'b00, 8'hA5});
    @(negedge clk);
    chk("w1_done", {hif.done, hif.busy, pll_reset},
        3'b110);
    @(negedge clk);
    chk("w1_after", {hif.done, hif.busy, hif.cmd_ready},
        3'b001);
    chk("w1_mem", mem[8'h10], 8'hA5);

    // read burst of 4
    start_cmd(1'b0, 8'h20, 4'd3, 1'b0);
    collect_read();
    chk("r4_issue_cnt", nis, 4);
    chk("r4_mdainc", incs, 4'b1110);
    for (int i = 0; i < 4; i++) begin
      chk("r4_issue_cyc", isc[i], 1 + 2 * i);
      chk("r4_rd_cyc", rdc[i], 3 + 2 * i);
      chk("r4_rd_data", rdv[i], 8'(8'h20 + i));
    end
    chk("r4_rd_cnt", nrd, 4);
    chk("r4_done_at", done_at, 10);

    // stalled write burst of 3
    wr0 = wr_issues;
    stall_bad = 0;
    ninc = 0;
    start_cmd(1'b1, 8'h40, 4'd2, 1'b0);
    @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      for (int s = 0; s < 5; s++) begin
        if (hif.wr_ready !== 1'b1 || mdopc !== 2'b00)
          stall_bad++;
        @(negedge clk);
      end
      hif.wr_valid = 1'b1;
      hif.wr_data = 8'(8'h50 + b);
      @(negedge clk);
      hif.wr_valid = 1'b0;
      chk("w3_issue_op", mdopc, 2'b01);
      if (mdainc) ninc++;
      @(negedge clk);
    end
    chk("w3_stall_clean", stall_bad, 0);
    chk("w3_mdainc_cnt", ninc, 2);
    wait_done(at);
    chk("w3_done_seen", 32'(at > 0), 32'd1);
    chk("w3_issues", wr_issues - wr0, 3);
    chk("w3_mem0", mem[8'h40], 8'h50);
    chk("w3_mem1", mem[8'h41], 8'h51);
    chk("w3_mem2", mem[8'h42], 8'h52);
    @(negedge clk);

    // relock, lock returns 40 cycles after reset falls
    start_cmd(1'b1, 8'h08, 4'd0, 1'b1);
    @(negedge clk);
    hif.wr_valid = 1'b1;
    hif.wr_data = 8'h33;
    @(negedge clk);
    hif.wr_valid = 1'b0;
    pll_rst_phase(wdt);
    chk("rl_reset_width", wdt, 16);
    at = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (hif.done) begin
        at = k;
        break;
      end
      if (k == 40) pll_lock = 1'b1;
    end
    chk("rl_done_at", at, 43);
    chk("rl_err", hif.err_timeout, 1'b0);
    @(negedge clk);

    // relock with lock held low -> timeout
    start_cmd(1'b0, 8'h30, 4'd0, 1'b1);
    pll_rst_phase(wdt);
    chk("to_reset_width", wdt, 16);
    wait_done(at);
    chk("to_done_at", at, 101);
    chk("to_err_at_done", hif.err_timeout, 1'b1);
    repeat (3) @(negedge clk);
    chk("to_err_sticky", hif.err_timeout, 1'b1);
    start_cmd(1'b1, 8'h60, 4'd0, 1'b0);
    chk("to_err_cleared", hif.err_timeout, 1'b0);
    @(negedge clk);
    hif.wr_valid = 1'b1;
    hif.wr_data = 8'h77;
    @(negedge clk);
    hif.wr_valid = 1'b0;
    wait_done(at);
    chk("to_next_done", at, 2);
    chk("to_next_mem", mem[8'h60], 8'h77);
    @(negedge clk);

    // reset in the middle of a long read
    start_cmd(1'b0, 8'h80, 4'd15, 1'b0);
    repeat (5) @(negedge clk);
    chk("mr_pre_op", {mdopc, hif.rd_valid}, 3'b101);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_abort",
        {mdopc, pll_reset, hif.rd_valid, hif.busy,
         hif.cmd_ready},
        6'b000000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_ready", hif.cmd_ready, 1'b1);

    // read across the address wrap
    start_cmd(1'b0, 8'hFF, 4'd1, 1'b0);
    collect_read();
    chk("wr_issue_cnt", nis, 2);
    chk("wr_mdainc", incs, 4'b1000);
    chk("wr_rd0", rdv[0], 8'hFF);
    chk("wr_rd1", rdv[1], 8'h00);
    chk("wr_done_at", done_at, 6);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
